riscv_dmem_arbiter: RTL



---
 rtl/riscv_dmem_arbiter_if.sv | 51 +++++
 rtl/riscv_dmem_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/riscv_dmem_arbiter_if.sv
// ----------------------------------------------------------------
// riscv_dmem_arbiter_if : pipeline, debug and memory bus bundle
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

interface riscv_dmem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            p_MemRead;
  logic            p_MemWrite;
  logic [XLEN-1:0] p_dAddress;
  logic [XLEN-1:0] p_dWriteData;
  logic            p_stall;
  logic [XLEN-1:0] p_dReadData;

  logic            d_req;
  logic            d_we;
  logic            d_lock;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;

  logic            MemRead;
  logic            MemWrite;
  logic [XLEN-1:0] dAddress;
  logic [XLEN-1:0] dWriteData;
  logic [XLEN-1:0] dReadData;

  modport slave (
    input  p_MemRead, p_MemWrite, p_dAddress, p_dWriteData,
    input  d_req, d_we, d_lock, d_addr, d_wdata,
    input  dReadData,
    output p_stall, p_dReadData,
    output d_gnt, d_rvalid, d_rdata,
    output MemRead, MemWrite, dAddress, dWriteData
  );

  modport master (
    output p_MemRead, p_MemWrite, p_dAddress, p_dWriteData,
    output d_req, d_we, d_lock, d_addr, d_wdata,
    output dReadData,
    input  p_stall, p_dReadData,
    input  d_gnt, d_rvalid, d_rdata,
    input  MemRead, MemWrite, dAddress, dWriteData
  );
endinterface

`default_nettype wire

// File: rtl/riscv_dmem_arbiter.sv
// ----------------------------------------------------------------
// riscv_dmem_arbiter : shares the data-memory port between pipeline and debug
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module riscv_dmem_arbiter #(
  parameter int XLEN      = 32,
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_dmem_arbiter_if.slave   bus
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  typedef enum logic [0:0] {
    ARB      = 1'b0,
    DBG_LOCK = 1'b1
  } state_t;

  state_t               state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [BURST_W-1:0]   burst_cnt;
  logic                 rd_pending;
  logic                 rd_owner_dbg;

  logic                 p_req;
  logic                 forced_release;
  logic                 dbg_win;

  always_comb begin
    p_req          = bus.p_MemRead | bus.p_MemWrite;
    forced_release = (state == DBG_LOCK) && (burst_cnt == BURST_MAX) && p_req;
    if (state == ARB)
      dbg_win = bus.d_req & (~p_req | (wait_cnt == WAIT_MAX));
    else
      dbg_win = bus.d_req & ~forced_release;
  end

  // Loser is not latched: a refused master keeps presenting its request.
  assign bus.MemRead    = dbg_win ? (bus.d_req & ~bus.d_we) : bus.p_MemRead;
  assign bus.MemWrite   = dbg_win ? (bus.d_req &  bus.d_we) : bus.p_MemWrite;
  assign bus.dAddress   = dbg_win ? bus.d_addr  : (p_req ? bus.p_dAddress   : '0);
  assign bus.dWriteData = dbg_win ? bus.d_wdata : (p_req ? bus.p_dWriteData : '0);

  assign bus.d_gnt       = dbg_win;
  assign bus.p_stall     = dbg_win & p_req;
  assign bus.d_rvalid    = rd_pending & rd_owner_dbg;
  assign bus.d_rdata     = bus.dReadData;
  assign bus.p_dReadData = bus.dReadData;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB;
      wait_cnt     <= '0;
      burst_cnt    <= '0;
      rd_pending   <= 1'b0;
      rd_owner_dbg <= 1'b0;
    end else begin
      rd_pending   <= bus.MemRead;
      rd_owner_dbg <= dbg_win;

      if (dbg_win || !bus.d_req)
        wait_cnt <= '0;
      else if (p_req && (wait_cnt != WAIT_MAX))
        wait_cnt <= wait_cnt + WAIT_W'(1);

      case (state)
        ARB: begin
          if (dbg_win && bus.d_lock) begin
            state     <= DBG_LOCK;
            burst_cnt <= BURST_W'(1);
          end
        end
        DBG_LOCK: begin
          if (!bus.d_req || forced_release || (dbg_win && !bus.d_lock)) begin
            state     <= ARB;
            burst_cnt <= '0;
          end else if (burst_cnt != BURST_MAX) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
          end
        end
        default: begin
          state     <= ARB;
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
